// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch slice.
//  - XLEN_DEF  : default datapath width for fetch/decode
//  - NOP_DEF   : bubble / out-of-range instruction encoding
//  - opcode_t  : primary opcode field values used across the pipeline
//  - opcodeOf(): extracts the primary opcode field from an instruction word
package fetch_stage_pkg;

   localparam int          XLEN_DEF = 32;
   localparam logic [31:0] NOP_DEF  = 32'h0000_0000;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011,
      OP_BEQ   = 6'b000100
   } opcode_t;

   function automatic opcode_t opcodeOf(input logic [31:0] instr);
      return opcode_t'(instr[31:26]);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID boundary bundle between the fetch stage and its neighbours.
//  Control in : PCWrite (hazard unit), redirect / redirect_pc (EX branch logic)
//  IF/ID out  : InstrOut, PCOut, PCAdderOut, ValidOut, FetchFault
//  master : the fetch stage (drives IF/ID, receives control)
//  slave  : decode / hazard / branch side (drives control, receives IF/ID)
interface fetch_stage_if #(
   parameter int XLEN = 32
);

   logic            PCWrite;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] InstrOut;
   logic [XLEN-1:0] PCOut;
   logic [XLEN-1:0] PCAdderOut;
   logic            ValidOut;
   logic            FetchFault;

   modport master (
      input  PCWrite, redirect, redirect_pc,
      output InstrOut, PCOut, PCAdderOut, ValidOut, FetchFault
   );

   modport slave (
      output PCWrite, redirect, redirect_pc,
      input  InstrOut, PCOut, PCAdderOut, ValidOut, FetchFault
   );

endinterface

// File: rtl/fetch_stage_instr_rom.sv
// Read-only instruction memory with a combinational read port.
//  idx          in   XLEN  full-width word index (never truncated before the check)
//  data         out  XLEN  rom[idx], or NOP when idx is outside the ROM
//  out_of_range out  1     idx >= DEPTH
// Contents are fixed at elaboration from INIT_WORDS (word i at bits i*XLEN);
// the default image is all NOP words.
module instr_rom #(
   parameter int                    DEPTH      = 32,
   parameter int                    XLEN       = 32,
   parameter logic [XLEN-1:0]       NOP        = '0,
   parameter logic [DEPTH*XLEN-1:0] INIT_WORDS = {DEPTH{NOP}}
) (
   input  logic [XLEN-1:0] idx,
   output logic [XLEN-1:0] data,
   output logic            out_of_range
);

   localparam int AW = $clog2(DEPTH);

   // NOTE: the ROM is a constant net array, not a register file, so there is
   // no reset and no clock -- nothing here can be corrupted or needs clearing.
   logic [XLEN-1:0] mem [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign mem[i] = INIT_WORDS[i*XLEN +: XLEN];
   end

   // The range check uses every index bit, so a PC past the ROM can never
   // alias back onto a low word through the truncated address below.
   assign out_of_range = (idx >= XLEN'(DEPTH));
   assign data         = out_of_range ? NOP : mem[idx[AW-1:0]];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction ROM and IF/ID register.
//  clk    in   single clock, all state updates on posedge
//  rst_n  in   synchronous reset, active low
//  bus    fetch_stage_if.master
//           PCWrite/redirect/redirect_pc in; InstrOut/PCOut/PCAdderOut/
//           ValidOut/FetchFault out (all registered)
// Edge priority: reset > redirect > stall (PCWrite=0) > advance.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                         XLEN       = XLEN_DEF,
   parameter int                         IMEM_DEPTH = 32,
   parameter int                         PC_STEP    = 1,
   parameter logic [XLEN-1:0]            RESET_PC   = '0,
   parameter logic [XLEN-1:0]            NOP_INSTR  = XLEN'(NOP_DEF),
   parameter logic [IMEM_DEPTH*XLEN-1:0] INIT_WORDS = {IMEM_DEPTH{NOP_INSTR}}
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master bus
);

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   logic [XLEN-1:0] pcQ;
   logic [XLEN-1:0] pcNext;
   logic [XLEN-1:0] romIdx;
   logic [XLEN-1:0] romData;
   logic            romOutOfRange;

   // Flooring division: a target that is not a multiple of PC_STEP fetches
   // the word it falls inside and is not treated as a fault.
   assign romIdx = pcQ / STEP;
   assign pcNext = pcQ + STEP;   // modulo 2^XLEN by construction

   instr_rom #(
      .DEPTH      (IMEM_DEPTH),
      .XLEN       (XLEN),
      .NOP        (NOP_INSTR),
      .INIT_WORDS (INIT_WORDS)
   ) u_rom (
      .idx          (romIdx),
      .data         (romData),
      .out_of_range (romOutOfRange)
   );

   // NOTE: every register here is written with <= so all IF/ID fields and
   // the PC update from the same pre-edge values; '=' would let later lines
   // see the new PC and misreport PCOut.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcQ            <= RESET_PC;
         bus.InstrOut   <= NOP_INSTR;
         bus.PCOut      <= '0;
         bus.PCAdderOut <= '0;
         bus.ValidOut   <= 1'b0;
         bus.FetchFault <= 1'b0;
      end else if (bus.redirect) begin
         // Wrong-path fetch is dropped; PCOut/PCAdderOut keep their old values.
         pcQ            <= bus.redirect_pc;
         bus.InstrOut   <= NOP_INSTR;
         bus.ValidOut   <= 1'b0;
         bus.FetchFault <= 1'b0;
      end else if (bus.PCWrite) begin
         pcQ            <= pcNext;
         bus.InstrOut   <= romData;
         bus.PCOut      <= pcQ;
         bus.PCAdderOut <= pcNext;
         bus.ValidOut   <= 1'b1;
         bus.FetchFault <= romOutOfRange;
      end
      // Stall: nothing assigned, PC and IF/ID hold.
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the reference model's
// expected IF/ID contents, an independent monitor pops and compares after
// each rising edge.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 32;
   localparam int          STEP  = 1;
   localparam logic [31:0] RPC   = 32'h0;
   localparam logic [31:0] NOP   = 32'h0;

   function automatic logic [DEPTH*32-1:0] makeImage();
      logic [DEPTH*32-1:0] img;
      logic [31:0]         w;
      logic [5:0]          op;
      img = '0;
      for (int i = 0; i < DEPTH; i++) begin
         case (i % 4)
            0:       op = OP_RTYPE;
            1:       op = OP_LW;
            2:       op = OP_SW;
            default: op = OP_BEQ;
         endcase
         w = {op, 26'(32'(i) * 32'h0001_3579 + 32'h11)};
         if (i == 0) w = 32'h8C30_0000;
         img[i*32 +: 32] = w;
      end
      return img;
   endfunction

   localparam logic [DEPTH*32-1:0] IMAGE = makeImage();

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcAdd;
      logic        valid;
      logic        fault;
   } ifid_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_stage_if #(.XLEN(XLEN)) bus ();

   fetch_stage #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (DEPTH),
      .PC_STEP    (STEP),
      .RESET_PC   (RPC),
      .NOP_INSTR  (NOP),
      .INIT_WORDS (IMAGE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model state: the program counter and the word array.
   logic [31:0] romModel [DEPTH];
   logic [31:0] mPc;
   ifid_t       mOut;

   ifid_t expQ [$];
   string tagQ [$];
   int    nTests = 0;
   int    nFail  = 0;

   task automatic check(input string name, input ifid_t got, input ifid_t exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got instr=%h pc=%h pcAdd=%h valid=%b fault=%b, want instr=%h pc=%h pcAdd=%h valid=%b fault=%b",
                  name, got.instr, got.pc, got.pcAdd, got.valid, got.fault,
                  exp.instr, exp.pc, exp.pcAdd, exp.valid, exp.fault);
      end
   endtask

   // Apply one cycle of inputs, advance the model by the same edge, queue result.
   task automatic cycle(input string tag, input logic rst, input logic pcw,
                        input logic redir, input logic [31:0] rpc);
      longint unsigned wordIdx;
      @(negedge clk);
      rst_n           = rst;
      bus.PCWrite     = pcw;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      if (!rst) begin
         mPc  = RPC;
         mOut = '{instr: NOP, pc: 32'h0, pcAdd: 32'h0, valid: 1'b0, fault: 1'b0};
      end else if (redir) begin
         mPc        = rpc;
         mOut.instr = NOP;
         mOut.valid = 1'b0;
         mOut.fault = 1'b0;
      end else if (pcw) begin
         wordIdx    = longint'(mPc) / STEP;
         mOut.fault = (wordIdx >= DEPTH);
         mOut.instr = mOut.fault ? NOP : romModel[wordIdx];
         mOut.pc    = mPc;
         mOut.pcAdd = mPc + 32'(STEP);
         mOut.valid = 1'b1;
         mPc        = mPc + 32'(STEP);
      end
      expQ.push_back(mOut);
      tagQ.push_back(tag);
   endtask

   // Monitor: independent of stimulus, compares one result per rising edge.
   initial begin
      ifid_t obs;
      ifid_t exp;
      string tag;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            obs = '{instr: bus.InstrOut, pc: bus.PCOut, pcAdd: bus.PCAdderOut,
                    valid: bus.ValidOut, fault: bus.FetchFault};
            check(tag, obs, exp);
         end
      end
   end

   initial begin
      logic [31:0] rpc;
      int          waitCycles;
      for (int i = 0; i < DEPTH; i++) romModel[i] = IMAGE[i*32 +: 32];
      mPc             = RPC;
      mOut            = '0;
      rst_n           = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;

      // Reset held two edges, then straight run PCOut 0,1,2.
      cycle("reset0", 1'b0, 1'b1, 1'b0, 32'h0);
      cycle("reset1", 1'b0, 1'b1, 1'b1, 32'h7);
      for (int i = 0; i < 3; i++) cycle("run", 1'b1, 1'b1, 1'b0, 32'h0);
      // Stall three edges at PCOut=2, then resume at 3 and run up to PCOut=6.
      for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) cycle("resume", 1'b1, 1'b1, 1'b0, 32'h0);
      // Redirect to 12: bubble, then rom[12].
      cycle("redir12", 1'b1, 1'b1, 1'b1, 32'd12);
      cycle("target12", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("after12", 1'b1, 1'b1, 1'b0, 32'h0);
      // Redirect with stall on the same edge, then fetch rom[3].
      cycle("redirStall", 1'b1, 1'b0, 1'b1, 32'd3);
      cycle("target3", 1'b1, 1'b1, 1'b0, 32'h0);
      // Last ROM word, then first out-of-range PC.
      cycle("redirLast", 1'b1, 1'b1, 1'b1, 32'(DEPTH - 1));
      cycle("lastWord", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("pastEnd", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("pastEndStall", 1'b1, 1'b0, 1'b0, 32'h0);
      // PC wrap at the top of the address space.
      cycle("redirTop", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      cycle("wrapFetch", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("wrapped", 1'b1, 1'b1, 1'b0, 32'h0);
      // Mid-stream reset wins over redirect.
      cycle("midReset", 1'b0, 1'b1, 1'b1, 32'd9);
      cycle("postReset", 1'b1, 1'b1, 1'b0, 32'h0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                           : 32'($urandom_range(0, DEPTH + 8));
         cycle("random", ($urandom_range(0, 49) != 0),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), rpc);
      end

      // Drain the scoreboard with a bounded wait.
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         #2;
         waitCycles++;
      end
      nTests++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("FAIL drain: %0d results still queued, want 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
